mod_counter: RTL and testbench

MOD_COUNTER -- requirements
Module: mod_counter

---
 rtl/mod_counter.sv | 47 ++++
 tb/tb_mod_counter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mod_counter.sv
// Up/down modulo-MODULUS counter with count inhibit and a terminal-count output for cascading.
// Define MOD_COUNTER_LOAD_EN to add the synchronous load port LD and its data input D.
module mod_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk,
    input  logic             r,
    input  logic             EC,
    input  logic             UD,
`ifdef MOD_COUNTER_LOAD_EN
    input  logic             LD,
    input  logic [WIDTH-1:0] D,
`endif
    output logic [WIDTH-1:0] Q,
    output logic             TC
);

    // Reject parameter sets whose count range does not fit the register.
    if (WIDTH < 2 || WIDTH > 16 || MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_illegal
        $error("mod_counter: illegal WIDTH/MODULUS combination");
    end

    localparam logic [WIDTH-1:0] QMAX = WIDTH'(MODULUS - 1);

    // Load wins over counting; EC only inhibits counting, never the load.
    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            Q <= '0;
        end
`ifdef MOD_COUNTER_LOAD_EN
        else if (LD) begin
            Q <= (int'(D) >= MODULUS) ? QMAX : D;
        end
`endif
        else if (!EC) begin
            if (UD) begin
                Q <= (Q == QMAX) ? '0 : Q + 1'b1;
            end else begin
                Q <= (Q == '0) ? QMAX : Q - 1'b1;
            end
        end
    end

    assign TC = !EC && (UD ? (Q == QMAX) : (Q == '0));

endmodule

// File: tb/tb_mod_counter.sv
// Scoreboard bench for mod_counter: a default instance, a two-digit decade cascade
// and an 8-bit modulo-256 instance, all checked against arithmetic reference models.
module tb_mod_counter;

    localparam int M = 10;

    logic clock = 1'b0;
    logic rMain;
    logic rAux;
    logic mainEc;
    logic mainUd;
    logic mainLd;
    logic [3:0] mainD;
    logic [3:0] mainQ;
    logic mainTc;
    logic [3:0] unitsQ;
    logic unitsTc;
    logic [3:0] tensQ;
    logic tensTc;
    logic [7:0] wideQ;
    logic wideTc;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int mq;
        int mtc;
        int cq;
        int ctc;
        int wq;
        int wtc;
    } exp_t;

    exp_t sb[$];

    int modelMain = 0;
    int modelCasc = 0;
    int modelWide = 0;

    always #5 clock = ~clock;

    mod_counter dut (
        .clk(clock), .r(rMain), .EC(mainEc), .UD(mainUd),
`ifdef MOD_COUNTER_LOAD_EN
        .LD(mainLd), .D(mainD),
`endif
        .Q(mainQ), .TC(mainTc)
    );

    mod_counter units (
        .clk(clock), .r(rAux), .EC(1'b0), .UD(1'b1),
`ifdef MOD_COUNTER_LOAD_EN
        .LD(1'b0), .D(4'd0),
`endif
        .Q(unitsQ), .TC(unitsTc)
    );

    mod_counter tens (
        .clk(clock), .r(rAux), .EC(~unitsTc), .UD(1'b1),
`ifdef MOD_COUNTER_LOAD_EN
        .LD(1'b0), .D(4'd0),
`endif
        .Q(tensQ), .TC(tensTc)
    );

    mod_counter #(.WIDTH(8), .MODULUS(256)) wide (
        .clk(clock), .r(rAux), .EC(1'b0), .UD(1'b1),
`ifdef MOD_COUNTER_LOAD_EN
        .LD(1'b0), .D(8'd0),
`endif
        .Q(wideQ), .TC(wideTc)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int expTc(input int q, input logic ec, input logic ud);
        return (!ec && (ud ? (q == M - 1) : (q == 0))) ? 1 : 0;
    endfunction

    // The cascade and the wide counter count up on every edge; advance their models together.
    task automatic pushEntry();
        exp_t e;
        modelCasc = (modelCasc + 1) % 100;
        modelWide = (modelWide + 1) % 256;
        e.mq  = modelMain;
        e.mtc = expTc(modelMain, mainEc, mainUd);
        e.cq  = modelCasc;
        e.ctc = (modelCasc == 99) ? 1 : 0;
        e.wq  = modelWide;
        e.wtc = (modelWide == 255) ? 1 : 0;
        sb.push_back(e);
    endtask

    task automatic applyStimulus(input logic ec, input logic ud, input logic ld, input int d);
        mainEc = ec;
        mainUd = ud;
        mainLd = ld;
        mainD  = 4'(d);
`ifdef MOD_COUNTER_LOAD_EN
        if (ld) begin
            modelMain = (d >= M) ? M - 1 : d;
        end else
`endif
        if (!ec) begin
            modelMain = ud ? (modelMain + 1) % M : (modelMain + M - 1) % M;
        end
        pushEntry();
        @(negedge clock);
    endtask

    // Assert reset between edges, confirm it acts without a clock, then hold it across one edge.
    task automatic pulseReset();
        #2 rMain = 1'b1;
        #1;
        check("asyncResetQ", int'(mainQ), 0);
        check("asyncResetTc", int'(mainTc), expTc(0, mainEc, mainUd));
        modelMain = 0;
        mainLd = $urandom_range(0, 1);
        mainD  = 4'($urandom_range(0, 15));
        pushEntry();
        @(negedge clock);
        rMain  = 1'b0;
        mainLd = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("mainQ", int'(mainQ), e.mq);
                check("mainTc", int'(mainTc), e.mtc);
                check("cascadeQ", int'(tensQ) * 10 + int'(unitsQ), e.cq);
                check("cascadeTc", int'(tensTc), e.ctc);
                check("wideQ", int'(wideQ), e.wq);
                check("wideTc", int'(wideTc), e.wtc);
            end
        end
    end

    initial begin : stimulus
        rMain  = 1'b1;
        rAux   = 1'b1;
        mainEc = 1'b0;
        mainUd = 1'b0;
        mainLd = 1'b0;
        mainD  = 4'd0;
        #3;
        check("resetMainQ", int'(mainQ), 0);
        check("resetMainTc", int'(mainTc), 1);
        check("resetWideQ", int'(wideQ), 0);
        @(negedge clock);
        rMain = 1'b0;
        rAux  = 1'b0;

        for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b1, 1'b0, 0);
        pulseReset();
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 1'b0, 0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, $urandom_range(0, 1), 1'b0, 0);
        pulseReset();
`ifdef MOD_COUNTER_LOAD_EN
        applyStimulus(1'b1, 1'b1, 1'b1, 7);
        applyStimulus(1'b0, 1'b1, 1'b1, 13);
        applyStimulus(1'b0, 1'b1, 1'b1, 3);
        applyStimulus(1'b0, 1'b0, 1'b1, 10);
`endif
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                pulseReset();
            end else begin
                applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 1),
                              $urandom_range(0, 7) == 0, $urandom_range(0, 15));
            end
        end

        @(posedge clock);
        #2;
        check("scoreboardDrained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
